// File: rtl/ram_responder.sv
// Single-port RAM responder: arbitrates IF fetches and MEM loads/stores onto one
// array, posting stores through a one-entry write buffer that forwards to reads.
module ram_responder #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  gclk,
   input  logic                  grst,
   input  logic                  IfReqValid,
   input  logic [ADDR_WIDTH-1:0] IfReqAddr,
   output logic                  IfStall,
   output logic                  IfRespValid,
   output logic [DATA_WIDTH-1:0] IfRespData,
   input  logic                  MemReqValid,
   input  logic                  MemReqWrite,
   input  logic [ADDR_WIDTH-1:0] MemReqAddr,
   input  logic [DATA_WIDTH-1:0] MemReqData,
   output logic                  MemRespValid,
   output logic [DATA_WIDTH-1:0] MemRespData,
   output logic                  WbPending
);

   localparam int DEPTH = 2**ADDR_WIDTH;

   typedef enum logic [1:0] {
      GRANT_IDLE  = 2'd0,
      GRANT_LOAD  = 2'd1,
      GRANT_DRAIN = 2'd2,
      GRANT_FETCH = 2'd3
   } grant_e;

   logic [DATA_WIDTH-1:0] ram_r [DEPTH];
   logic                  wb_valid_r;
   logic [ADDR_WIDTH-1:0] wb_addr_r;
   logic [DATA_WIDTH-1:0] wb_data_r;

   grant_e                grant_s;
   logic                  mem_load_s;
   logic                  mem_store_s;
   logic [ADDR_WIDTH-1:0] rd_addr_s;
   logic [DATA_WIDTH-1:0] rd_data_s;

   // Single-port grant: load, then drain, then fetch; nothing is granted in reset
   always_comb begin
      mem_load_s  = 1'b0;
      mem_store_s = 1'b0;
      grant_s     = GRANT_IDLE;
      if (grst) begin
         grant_s = GRANT_IDLE;
      end else begin
         mem_load_s  = MemReqValid & ~MemReqWrite;
         mem_store_s = MemReqValid & MemReqWrite;
         if (mem_load_s) begin
            grant_s = GRANT_LOAD;
         end else if (wb_valid_r && (mem_store_s || !IfReqValid)) begin
            grant_s = GRANT_DRAIN;
         end else if (IfReqValid) begin
            grant_s = GRANT_FETCH;
         end else begin
            grant_s = GRANT_IDLE;
         end
      end
   end

   // Read source: the pre-edge write buffer shadows the array on an address hit
   always_comb begin
      rd_addr_s = (grant_s == GRANT_LOAD) ? MemReqAddr : IfReqAddr;
      rd_data_s = (wb_valid_r && (wb_addr_r == rd_addr_s)) ? wb_data_r : ram_r[rd_addr_s];
      IfStall   = IfReqValid && !grst && (grant_s != GRANT_FETCH);
   end

   // Array write port, used only by buffer drains; contents survive reset
   always_ff @(posedge gclk) begin
      if (grant_s == GRANT_DRAIN) begin
         ram_r[wb_addr_r] <= wb_data_r;
      end
   end

   // Posted write buffer: a new store refills it in the same edge it drains
   always_ff @(posedge gclk) begin
      if (grst) begin
         wb_valid_r <= 1'b0;
         wb_addr_r  <= '0;
         wb_data_r  <= '0;
      end else if (mem_store_s) begin
         wb_valid_r <= 1'b1;
         wb_addr_r  <= MemReqAddr;
         wb_data_r  <= MemReqData;
      end else if (grant_s == GRANT_DRAIN) begin
         wb_valid_r <= 1'b0;
      end
   end

   // Registered responses; data registers hold between grants
   always_ff @(posedge gclk) begin
      if (grst) begin
         IfRespValid  <= 1'b0;
         IfRespData   <= '0;
         MemRespValid <= 1'b0;
         MemRespData  <= '0;
      end else begin
         IfRespValid  <= (grant_s == GRANT_FETCH);
         MemRespValid <= (grant_s == GRANT_LOAD);
         if (grant_s == GRANT_FETCH) begin
            IfRespData <= rd_data_s;
         end
         if (grant_s == GRANT_LOAD) begin
            MemRespData <= rd_data_s;
         end
      end
   end

   assign WbPending = wb_valid_r;

endmodule

// File: doc/ram_responder.md
Name: ram_responder

Overview:
- Single-port synchronous RAM responder. It is the memory-side end of the load/store and instruction-fetch interfaces.
- It arbitrates two initiators onto one internal RAM array:
  - IF fetch port, read-only.
  - MEM stage port, load/store.
- MEM stores go into a one-entry posted write buffer, so stores never back-pressure the pipeline. Loads and fetches forward from that buffer.
- Registered read data, one-cycle latency; IF receives a stall when it loses arbitration.

Parameters:
- DATA_WIDTH, 16, word width.
- ADDR_WIDTH, 8, word address width; array depth is 2**ADDR_WIDTH.

Ports:
- gclk  input  1  clock, all state updates on posedge.
- grst  input  1  synchronous active-high reset.
- IfReqValid  input  1  IF fetch request.
- IfReqAddr  input  ADDR_WIDTH  IF fetch address.
- IfStall  output  1  combinational; 1 when an IF request is not granted this cycle.
- IfRespValid  output  1  registered; fetch data valid.
- IfRespData  output  DATA_WIDTH  registered fetch data.
- MemReqValid  input  1  MEM request.
- MemReqWrite  input  1  1 = store, 0 = load.
- MemReqAddr  input  ADDR_WIDTH  MEM address.
- MemReqData  input  DATA_WIDTH  store data.
- MemRespValid  output  1  registered; load data valid.
- MemRespData  output  DATA_WIDTH  registered load data.
- WbPending  output  1  write buffer holds an undrained store.

Behaviour:
- Reset:
  - On posedge gclk with grst=1: IfRespValid=0, MemRespValid=0, IfRespData=0, MemRespData=0, write buffer invalid (WbPending=0).
  - A buffered store present at reset is discarded.
  - RAM array contents are not cleared.
  - IfStall is 0 during reset regardless of IfReqValid.
- Write buffer (WB) holds {valid, addr, data}.
- Port grant: exactly one RAM operation per cycle, chosen in priority order:
  1. MEM load (MemReqValid & !MemReqWrite).
  2. WB drain, if WB valid and (MEM store present this cycle, or IfReqValid=0).
  3. IF read, if IfReqValid.
  4. Otherwise idle.
- Stores:
  - Always accepted in the cycle presented.
  - If WB is valid, it drains in that cycle (rule 2) and the new store is loaded into WB.
  - If WB is empty, the new store is loaded into WB and no drain occurs.
  - No MEM back-pressure signal exists.
- Drain: RAM[WB.addr] <= WB.data at posedge. WB becomes invalid unless it is refilled the same edge.
- Load and fetch data source:
  - If WB valid and the address equals WB.addr, data = WB.data (forward).
  - Otherwise data = RAM[addr].
  - The WB contents used are those before the current edge's update.
- Load result: registered at the next posedge; MemRespValid=1 for exactly one cycle per load.
- Fetch result: on grant, registered at the next posedge; IfRespValid=1 for one cycle.
- IfStall:
  - IfStall=1 when IfReqValid=1 and the grant is not IF (a MEM load or a rule-2 drain wins).
  - When stalled, IF holds its address and no IfRespValid pulse is produced for that cycle.
- Response valids deassert in any cycle without a corresponding grant. Data registers hold their last value when not updated.
- Back-to-back loads and fetches: one per cycle, fully pipelined.
- Store to address X followed by a load of X in the next cycle returns the new data via forwarding, or via RAM if already drained.
- Store followed immediately by a store to the same address: the older value drains to RAM, the newer value sits in WB. The final value is the newer one.
- Address wrap: addresses are ADDR_WIDTH bits; no out-of-range condition exists.

Test Plan:
- Reset:
  - Stimulus: grst=1 for 2 cycles with IfReqValid=1, then release.
  - Response: all valids 0, WbPending=0, IfStall=0 during reset.
  - First fetch after release returns RAM contents with IfRespValid the cycle after the request.
- Store then load:
  - Stimulus: store 16'hBEEF to 0x10, next cycle load 0x10.
  - Response: MemRespData=16'hBEEF, MemRespValid=1 one cycle after the load (forwarded).
  - WbPending stays 1 until an idle cycle drains it.
- Load vs fetch contention:
  - Stimulus: MEM load 0x20 and IF fetch 0x00 in the same cycle, with RAM[0x20]=16'h1234 and RAM[0x00]=16'hA5A5.
  - Response: IfStall=1; next cycle MemRespData=16'h1234.
  - IF retried the following cycle gets 16'hA5A5 one cycle later.
- Store stream:
  - Stimulus: stores of 1, 2, 3 to 0x30, 0x31, 0x30 on consecutive cycles, with IF fetching continuously.
  - Response: IfStall=1 on cycles 2 and 3 (drains). Afterwards RAM[0x30]=3 and RAM[0x31]=2. No store is lost.
- Fetch forwarding:
  - Stimulus: store 16'h00FF to 0x40 with IF idle, then IF fetch 0x40 while WB is still valid.
  - Response: IfRespData=16'h00FF, IfStall=0.
- Reset mid-operation:
  - Stimulus: store 16'h5555 to 0x50 (previous value 16'h1111), assert grst the next cycle before any drain.
  - Response: WbPending=0; a later load of 0x50 returns 16'h1111.
